// File: rtl/regfile_dump_reader.sv
// Debug read-out engine: walks the register file and streams each word out over valid/ready.
// Optional trailing XOR checksum beat is enabled by defining DUMP_CHECKSUM_EN.
module regfile_dump_reader #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_REGS   = 32,
  localparam int IDX_W     = $clog2(NUM_REGS)
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Start,
  input  logic                  Abort,
  output logic [IDX_W-1:0]      RA,
  input  logic [DATA_WIDTH-1:0] BusA,
  output logic [DATA_WIDTH-1:0] DumpData,
  output logic [IDX_W-1:0]      DumpIdx,
  output logic                  DumpSum,
  output logic                  DumpLast,
  output logic                  DumpValid,
  input  logic                  DumpReady,
  output logic                  Busy,
  output logic                  Done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    SEND = 3'd2,
`ifdef DUMP_CHECKSUM_EN
    SUM  = 3'd3,
`endif
    DONE = 3'd4
  } dumpState_t;

  dumpState_t             curState_r, nextState_s;
  logic [IDX_W-1:0]       raNext_s, idxNext_s;
  logic [DATA_WIDTH-1:0]  dataNext_s;
  logic                   sumNext_s, lastNext_s, validNext_s, busyNext_s, doneNext_s;

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]  checksum_r, checksumNext_s;

  function automatic logic [DATA_WIDTH-1:0] foldXor(input logic [DATA_WIDTH-1:0] acc,
                                                    input logic [DATA_WIDTH-1:0] word);
    return acc ^ word;
  endfunction
`endif

  // Next-state and next-output decode; outputs are registered below.
  always_comb begin
    nextState_s = curState_r;
    raNext_s    = RA;
    dataNext_s  = DumpData;
    idxNext_s   = DumpIdx;
    sumNext_s   = DumpSum;
    lastNext_s  = DumpLast;
    validNext_s = DumpValid;
    busyNext_s  = Busy;
    doneNext_s  = 1'b0;
`ifdef DUMP_CHECKSUM_EN
    checksumNext_s = checksum_r;
`endif
    if (Abort && (curState_r != IDLE)) begin
      // Abort beats a same-edge handshake and never produces Done.
      nextState_s = IDLE;
      raNext_s    = {IDX_W{1'b0}};
      validNext_s = 1'b0;
      sumNext_s   = 1'b0;
      lastNext_s  = 1'b0;
      busyNext_s  = 1'b0;
    end else begin
      case (curState_r)
        IDLE: begin
          if (Start) begin
            nextState_s = ADDR;
            raNext_s    = {IDX_W{1'b0}};
            busyNext_s  = 1'b1;
`ifdef DUMP_CHECKSUM_EN
            checksumNext_s = {DATA_WIDTH{1'b0}};
`endif
          end else begin
            nextState_s = IDLE;
          end
        end
        ADDR: begin
          nextState_s = SEND;
          dataNext_s  = BusA;
          idxNext_s   = RA;
          validNext_s = 1'b1;
          sumNext_s   = 1'b0;
`ifdef DUMP_CHECKSUM_EN
          lastNext_s     = 1'b0;
          checksumNext_s = foldXor(checksum_r, BusA);
`else
          lastNext_s  = (RA == LAST_IDX);
`endif
        end
        SEND: begin
          if (DumpReady) begin
            validNext_s = 1'b0;
            lastNext_s  = 1'b0;
            if (RA != LAST_IDX) begin
              nextState_s = ADDR;
              raNext_s    = RA + IDX_ONE;
            end else begin
`ifdef DUMP_CHECKSUM_EN
              nextState_s = SUM;
              dataNext_s  = checksum_r;
              idxNext_s   = LAST_IDX;
              sumNext_s   = 1'b1;
              lastNext_s  = 1'b1;
              validNext_s = 1'b1;
`else
              nextState_s = DONE;
              raNext_s    = {IDX_W{1'b0}};
              busyNext_s  = 1'b0;
              doneNext_s  = 1'b1;
`endif
            end
          end else begin
            nextState_s = SEND;
          end
        end
`ifdef DUMP_CHECKSUM_EN
        SUM: begin
          if (DumpReady) begin
            nextState_s = DONE;
            validNext_s = 1'b0;
            sumNext_s   = 1'b0;
            lastNext_s  = 1'b0;
            raNext_s    = {IDX_W{1'b0}};
            busyNext_s  = 1'b0;
            doneNext_s  = 1'b1;
          end else begin
            nextState_s = SUM;
          end
        end
`endif
        DONE: begin
          nextState_s = IDLE;
        end
        default: begin
          nextState_s = IDLE;
          raNext_s    = {IDX_W{1'b0}};
          validNext_s = 1'b0;
          sumNext_s   = 1'b0;
          lastNext_s  = 1'b0;
          busyNext_s  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      curState_r <= IDLE;
      RA         <= {IDX_W{1'b0}};
      DumpData   <= {DATA_WIDTH{1'b0}};
      DumpIdx    <= {IDX_W{1'b0}};
      DumpSum    <= 1'b0;
      DumpLast   <= 1'b0;
      DumpValid  <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
    end else begin
      curState_r <= nextState_s;
      RA         <= raNext_s;
      DumpData   <= dataNext_s;
      DumpIdx    <= idxNext_s;
      DumpSum    <= sumNext_s;
      DumpLast   <= lastNext_s;
      DumpValid  <= validNext_s;
      Busy       <= busyNext_s;
      Done       <= doneNext_s;
    end
  end

`ifdef DUMP_CHECKSUM_EN
  // Running XOR of every captured word.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      checksum_r <= {DATA_WIDTH{1'b0}};
    end else begin
      checksum_r <= checksumNext_s;
    end
  end
`endif

endmodule
